// File: rtl/ssd_pkg.sv
// Shared definitions for the segment-display drivers: blank pattern, scroll
// direction encoding and modular index arithmetic.
package ssd_pkg;

  localparam int SSD_MAX_SEG_W = 64;
  localparam logic [SSD_MAX_SEG_W-1:0] SSD_BLANK = '1;

  localparam int SSD_IDX_W = 16;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // (a + b) mod m for a, b < m: one compare-and-subtract, no divider.
  function automatic logic [SSD_IDX_W-1:0] wrap_add(
    input logic [SSD_IDX_W-1:0] a,
    input logic [SSD_IDX_W-1:0] b,
    input logic [SSD_IDX_W-1:0] m
  );
    logic [SSD_IDX_W-1:0] s;
    s = a + b;
    if (s >= m) s = s - m;
    return s;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Divide-by-DIV strobe: one-cycle tick at terminal count while enabled.
// Counter holds its phase while en=0; clr restarts it synchronously.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ssd_marquee.sv
// Scrolling message driver for a multiplexed segment display: message buffer,
// rotating head pointer, digit scan and a registered display bus.
module ssd_marquee
  import ssd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SEG_W     = 15,
  parameter int MSG_LEN   = 6,
  parameter int SCAN_DIV  = 50000,
  parameter int SHIFT_DIV = 25000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MSG_LEN*SEG_W-1:0]     msg,
  input  logic                         load,
  input  logic                         run,
  input  logic                         dir,
  output logic [SEG_W+DIGITS-1:0]      display,
  output logic [$clog2(MSG_LEN)-1:0]   head
);

  localparam int HW = $clog2(MSG_LEN);
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SEG_W-1:0] BLANK = SSD_BLANK[SEG_W-1:0];
  localparam logic [SEG_W+DIGITS-1:0] DISPLAY_RST = {BLANK, {(DIGITS-1){1'b1}}, 1'b0};

  if (MSG_LEN < DIGITS) begin : g_len_check
    $error("ssd_marquee: MSG_LEN must be >= DIGITS");
  end

  logic [SEG_W-1:0] buffer [MSG_LEN];
  logic [SW-1:0]    sc;
  logic             scan_tick;
  logic             shift_tick;
  logic [HW-1:0]    sym_idx;
  logic [HW-1:0]    head_next_left;
  logic [HW-1:0]    head_next_right;

  tick_gen #(.DIV(SCAN_DIV)) u_scan (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .clr  (1'b0),
    .tick (scan_tick)
  );

  tick_gen #(.DIV(SHIFT_DIV)) u_shift (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clr  (load),
    .tick (shift_tick)
  );

  always_comb begin
    sym_idx         = HW'(wrap_add(SSD_IDX_W'(head), SSD_IDX_W'(sc), SSD_IDX_W'(MSG_LEN)));
    head_next_left  = HW'(wrap_add(SSD_IDX_W'(head), SSD_IDX_W'(1), SSD_IDX_W'(MSG_LEN)));
    head_next_right = HW'(wrap_add(SSD_IDX_W'(head), SSD_IDX_W'(MSG_LEN - 1), SSD_IDX_W'(MSG_LEN)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) buffer[i] <= BLANK;
    end else if (load) begin
      for (int i = 0; i < MSG_LEN; i++) buffer[i] <= msg[i*SEG_W +: SEG_W];
    end
  end

  // A load wins over a coincident scroll tick; that tick is simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
    end else if (load) begin
      head <= '0;
    end else if (shift_tick) begin
      head <= (dir == DIR_RIGHT) ? head_next_right : head_next_left;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc <= '0;
    end else if (scan_tick) begin
      sc <= (sc == SW'(DIGITS - 1)) ? '0 : sc + SW'(1);
    end
  end

  // Refreshed every cycle, so any head, buffer or scan change shows one clk later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display <= DISPLAY_RST;
    end else begin
      display <= {buffer[sym_idx], ~(DIGITS'(1) << sc)};
    end
  end

endmodule

// File: tb/tb_ssd_marquee.sv
// Bench for ssd_marquee: directed scenarios with literal expectations plus a
// random phase, all checked every cycle against an arithmetic reference model.
module tb_ssd_marquee;

  localparam int DIGITS    = 4;
  localparam int SEG_W     = 15;
  localparam int MSG_LEN   = 6;
  localparam int SCAN_DIV  = 2;
  localparam int SHIFT_DIV = 8;
  localparam int DW        = SEG_W + DIGITS;
  localparam int HW        = $clog2(MSG_LEN);
  localparam logic [DW-1:0] RESET_DISP = {15'h7FFF, 4'b1110};

  logic                       clk = 1'b0;
  logic                       rst;
  logic [MSG_LEN*SEG_W-1:0]   msg;
  logic                       load;
  logic                       run;
  logic                       dir;
  logic [DW-1:0]              display;
  logic [HW-1:0]              head;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ssd_marquee #(
    .DIGITS(DIGITS), .SEG_W(SEG_W), .MSG_LEN(MSG_LEN),
    .SCAN_DIV(SCAN_DIV), .SHIFT_DIV(SHIFT_DIV)
  ) dut (
    .clk(clk), .rst(rst), .msg(msg), .load(load), .run(run), .dir(dir),
    .display(display), .head(head)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [SEG_W-1:0] m_buf [MSG_LEN];
  int m_head, m_sc, m_shift, m_scan;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) m_buf[i] = '1;
      m_head = 0; m_sc = 0; m_shift = 0; m_scan = 0;
      exp_q.delete();
    end else begin
      exp_q.push_back({m_buf[(m_head + m_sc) % MSG_LEN], ~(4'b0001 << m_sc)});
      if (m_scan == SCAN_DIV - 1) begin
        m_scan = 0;
        m_sc = (m_sc + 1) % DIGITS;
      end else begin
        m_scan++;
      end
      if (load) begin
        for (int i = 0; i < MSG_LEN; i++) m_buf[i] = msg[i*SEG_W +: SEG_W];
        m_head = 0;
        m_shift = 0;
      end else if (run) begin
        if (m_shift == SHIFT_DIV - 1) begin
          m_shift = 0;
          m_head = dir ? (m_head + MSG_LEN - 1) % MSG_LEN : (m_head + 1) % MSG_LEN;
        end else begin
          m_shift++;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [DW-1:0] e;
    e = (exp_q.size() == 0) ? RESET_DISP : exp_q.pop_front();
    check("display", display, e);
    check("head", head, m_head);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_head_change(input int limit, output int cyc);
    logic [HW-1:0] h0;
    h0 = head;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (head == h0 && cyc < limit);
    if (head == h0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL head_step_timeout: no step within %0d cycles", limit);
    end
  endtask

  task automatic pulse_load(input logic [MSG_LEN*SEG_W-1:0] m);
    msg = m;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [3:0] seq[$];
    int hold[$];
    logic [SEG_W-1:0] seen [DIGITS];
    logic [MSG_LEN*SEG_W-1:0] m;
    int cyc;
    int h;

    rst = 1'b0; load = 1'b0; run = 1'b0; dir = 1'b0; msg = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Blank scan after reset: one-cold digit walk, each digit held 2 clk.
    seq.push_back(display[3:0]);
    hold.push_back(1);
    repeat (12) begin
      @(negedge clk);
      if (display[3:0] == seq[$]) hold[$]++;
      else begin
        seq.push_back(display[3:0]);
        hold.push_back(1);
      end
      check("blank_seg", display[DW-1:4], 15'h7FFF);
    end
    check("scan_seq0", seq[0], 4'b1110);
    check("scan_seq1", seq[1], 4'b1101);
    check("scan_seq2", seq[2], 4'b1011);
    check("scan_seq3", seq[3], 4'b0111);
    check("scan_hold1", hold[1], 2);
    check("scan_hold2", hold[2], 2);
    check("reset_head", head, 0);

    // Load symbols i+1, scroll left one step per 8 clk up to head=4.
    for (int i = 0; i < MSG_LEN; i++) m[i*SEG_W +: SEG_W] = SEG_W'(i + 1);
    run = 1'b1; dir = 1'b0;
    pulse_load(m);
    check("load_head", head, 0);
    for (int s = 1; s <= 4; s++) begin
      wait_head_change(20, cyc);
      check("left_step_period", cyc, 8);
      check("left_step_head", head, s);
    end
    run = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < DIGITS; k++) seen[k] = '0;
    repeat (8) begin
      @(negedge clk);
      for (int k = 0; k < DIGITS; k++)
        if (display[k] == 1'b0) seen[k] = display[DW-1:4];
    end
    check("head4_dig0", seen[0], 5);
    check("head4_dig1", seen[1], 6);
    check("head4_dig2", seen[2], 1);
    check("head4_dig3", seen[3], 2);
    check("frozen_head", head, 4);

    // Wrap 5 -> 0, then reverse: 0 -> 5 -> 4.
    run = 1'b1;
    wait_head_change(20, cyc);
    check("step_to5", head, 5);
    wait_head_change(20, cyc);
    check("wrap_to0", head, 0);
    dir = 1'b1;
    wait_head_change(20, cyc);
    check("right_wrap_head", head, 5);
    check("right_step_period", cyc, 8);
    wait_head_change(20, cyc);
    check("right_step_head", head, 4);

    // Freeze at counter value 5 for 20 clk; resume needs 3 more clk.
    repeat (5) @(negedge clk);
    run = 1'b0;
    h = head;
    repeat (20) @(negedge clk);
    check("run0_hold", head, h);
    run = 1'b1;
    wait_head_change(20, cyc);
    check("resume_latency", cyc, 3);
    check("resume_head", head, 3);

    // Load lands on the same edge as a shift tick at head=3.
    dir = 1'b0;
    repeat (7) @(negedge clk);
    for (int i = 0; i < MSG_LEN; i++) m[i*SEG_W +: SEG_W] = SEG_W'(16'h0100 + i);
    pulse_load(m);
    check("load_beats_tick", head, 0);
    wait_head_change(20, cyc);
    check("post_load_period", cyc, 8);
    check("post_load_head", head, 1);

    // Asynchronous reset between edges while scrolling.
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_head", head, 0);
    check("async_rst_display", display, RESET_DISP);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("post_rst_blank", display[DW-1:4], 15'h7FFF);
    end

    // Random run/dir/load traffic against the model.
    repeat (600) begin
      @(negedge clk);
      run = ($urandom_range(0, 3) != 0);
      dir = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 24) == 0);
      if (load)
        for (int i = 0; i < MSG_LEN; i++) msg[i*SEG_W +: SEG_W] = SEG_W'($urandom);
    end
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
